// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM states and field widths.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } uart_state_e;

    localparam int BYTE_W = 8;
    localparam int BAUD_W = 4;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin select: the search begins just after the last winner.
module uart_rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic             w_found;
    logic [IDX_W-1:0] w_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = IDX_W'((int'(last) + k) % N_REQ);
            if (!w_found && req[w_idx]) begin
                w_found      = 1'b1;
                grant[w_idx] = 1'b1;
                grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX core among N_REQ requesters: round-robin grant, capture,
// send with timeout, forced idle gap, and a per-requester acknowledge.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [BYTE_W*N_REQ-1:0]  req_data,
    input  logic [BAUD_W*N_REQ-1:0]  req_baud,
    output logic [N_REQ-1:0]         ack,
    output logic                     ack_err,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic [BYTE_W-1:0]        tx_data,
    output logic                     tx_send_en,
    output logic [BAUD_W-1:0]        tx_baud_set,
    input  logic                     tx_done
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam int GAP_W = 8;

    uart_state_e       r_state;
    uart_state_e       w_next;
    logic [IDX_W-1:0]  r_last;
    logic [IDX_W-1:0]  r_grant;
    logic [N_REQ-1:0]  r_grant_oh;
    logic [BYTE_W-1:0] r_tx_data;
    logic [BAUD_W-1:0] r_tx_baud;
    logic              r_send_en;
    logic [N_REQ-1:0]  r_ack;
    logic              r_ack_err;
    logic [CNT_W-1:0]  r_cnt;
    logic [GAP_W-1:0]  r_gap;

    logic [N_REQ-1:0]  w_pick_oh;
    logic [IDX_W-1:0]  w_pick_idx;
    logic [BYTE_W-1:0] w_sel_data;
    logic [BAUD_W-1:0] w_sel_baud;
    logic              w_exit;
    logic              w_abort;

    uart_rr_picker #(
        .N_REQ(N_REQ)
    ) u_picker (
        .req      (req),
        .last     (r_last),
        .grant    (w_pick_oh),
        .grant_idx(w_pick_idx)
    );

    always_comb begin
        w_sel_data = '0;
        w_sel_baud = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_idx == IDX_W'(i)) begin
                w_sel_data = req_data[i*BYTE_W +: BYTE_W];
                w_sel_baud = req_baud[i*BAUD_W +: BAUD_W];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // tx_done has priority over the timeout when both land in the same cycle.
    always_comb begin
        w_next  = r_state;
        w_exit  = 1'b0;
        w_abort = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|req) w_next = ST_SEND;
            end
            ST_SEND: begin
                if (tx_done) begin
                    w_next = ST_GAP;
                    w_exit = 1'b1;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    w_next  = ST_GAP;
                    w_exit  = 1'b1;
                    w_abort = 1'b1;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_W'(GAP_CYCLES - 1)) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last     <= IDX_W'(N_REQ - 1);
            r_grant    <= '0;
            r_grant_oh <= '0;
            r_tx_data  <= '0;
            r_tx_baud  <= '0;
            r_send_en  <= 1'b0;
            r_ack      <= '0;
            r_ack_err  <= 1'b0;
            r_cnt      <= '0;
            r_gap      <= '0;
        end else begin
            r_ack     <= '0;
            r_ack_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_tx_data  <= w_sel_data;
                        r_tx_baud  <= w_sel_baud;
                        r_grant    <= w_pick_idx;
                        r_grant_oh <= w_pick_oh;
                        r_last     <= w_pick_idx;
                        r_send_en  <= 1'b1;
                        r_cnt      <= '0;
                    end
                end
                ST_SEND: begin
                    if (w_exit) begin
                        r_send_en <= 1'b0;
                        r_ack     <= r_grant_oh;
                        r_ack_err <= w_abort;
                        r_gap     <= '0;
                    end else if (r_cnt != '1) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    r_gap <= r_gap + GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign ack         = r_ack;
    assign ack_err     = r_ack_err;
    assign busy        = (r_state != ST_IDLE);
    assign grant_id    = r_grant;
    assign tx_data     = r_tx_data;
    assign tx_send_en  = r_send_en;
    assign tx_baud_set = r_tx_baud;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a stub TX core driven from the bench.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int GAP = 2;
    localparam int TMO = 50;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [3:0]  req      = '0;
    logic [31:0] req_data = '0;
    logic [15:0] req_baud = '0;
    logic        tx_done  = 1'b0;

    logic [3:0]  ack;
    logic        ack_err;
    logic        busy;
    logic [1:0]  grant_id;
    logic [7:0]  tx_data;
    logic        tx_send_en;
    logic [3:0]  tx_baud_set;

    int errors = 0;
    int checks = 0;

    uart_tx_arbiter #(
        .N_REQ(N),
        .GAP_CYCLES(GAP),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req(req),
        .req_data(req_data),
        .req_baud(req_baud),
        .ack(ack),
        .ack_err(ack_err),
        .busy(busy),
        .grant_id(grant_id),
        .tx_data(tx_data),
        .tx_send_en(tx_send_en),
        .tx_baud_set(tx_baud_set),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tick(1);
        tx_done = 1'b0;
    endtask

    task automatic wait_send(output bit ok);
        int n = 0;
        while (!tx_send_en && n < 30) begin
            tick(1);
            n++;
        end
        ok = tx_send_en;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        tick(1);
        checks++; if ({ack, ack_err, busy, grant_id, tx_data, tx_send_en, tx_baud_set} !== 21'd0) begin
            errors++; $display("FAIL reset_outputs: got %0h want 0", {ack, ack_err, busy, grant_id, tx_data, tx_send_en, tx_baud_set});
        end
        reset_n = 1'b1;
        tick(2);
        checks++; if (busy !== 1'b0 || tx_send_en !== 1'b0) begin
            errors++; $display("FAIL reset_idle: busy=%b send_en=%b want 0 0", busy, tx_send_en);
        end
    endtask

    task automatic test_single();
        req_data[7:0] = 8'h87;
        req_baud[3:0] = 4'd4;
        req = 4'b0001;
        tick(1);
        checks++; if (tx_send_en !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL single_grant: send_en=%b busy=%b want 1 1", tx_send_en, busy);
        end
        checks++; if (tx_data !== 8'h87 || tx_baud_set !== 4'd4 || grant_id !== 2'd0) begin
            errors++; $display("FAIL single_capture: data=%0h baud=%0d id=%0d want 87 4 0", tx_data, tx_baud_set, grant_id);
        end
        req_data[7:0] = 8'h11;
        req_baud[3:0] = 4'd9;
        tick(5);
        checks++; if (tx_data !== 8'h87 || tx_baud_set !== 4'd4 || tx_send_en !== 1'b1 || ack !== 4'd0) begin
            errors++; $display("FAIL single_hold: data=%0h baud=%0d send_en=%b ack=%b want 87 4 1 0000", tx_data, tx_baud_set, tx_send_en, ack);
        end
        pulse_done();
        checks++; if (ack !== 4'b0001 || ack_err !== 1'b0 || tx_send_en !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_ack: ack=%b err=%b send_en=%b busy=%b want 0001 0 0 1", ack, ack_err, tx_send_en, busy);
        end
        req = 4'b0000;
        tick(1);
        checks++; if (ack !== 4'd0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_ack_width: ack=%b busy=%b want 0000 1", ack, busy);
        end
        tick(1);
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL single_gap_end: busy=%b want 0", busy);
        end
    endtask

    task automatic test_simultaneous();
        int n_low;
        do_reset();
        req_data = 32'h0048_0087;
        req_baud = 16'h0304;
        req = 4'b0101;
        tick(1);
        checks++; if (grant_id !== 2'd0 || tx_data !== 8'h87) begin
            errors++; $display("FAIL simul_first: id=%0d data=%0h want 0 87", grant_id, tx_data);
        end
        tick(3);
        pulse_done();
        checks++; if (ack !== 4'b0001) begin
            errors++; $display("FAIL simul_ack0: ack=%b want 0001", ack);
        end
        req = 4'b0100;
        n_low = 0;
        while (!tx_send_en && n_low < 20) begin
            n_low++;
            tick(1);
        end
        checks++; if (n_low !== GAP + 1) begin
            errors++; $display("FAIL simul_gap: low_cycles=%0d want %0d", n_low, GAP + 1);
        end
        checks++; if (grant_id !== 2'd2 || tx_data !== 8'h48 || tx_baud_set !== 4'd3) begin
            errors++; $display("FAIL simul_second: id=%0d data=%0h baud=%0d want 2 48 3", grant_id, tx_data, tx_baud_set);
        end
        tick(2);
        pulse_done();
        checks++; if (ack !== 4'b0100 || ack_err !== 1'b0) begin
            errors++; $display("FAIL simul_ack2: ack=%b err=%b want 0100 0", ack, ack_err);
        end
        req = 4'b0000;
        tick(3);
    endtask

    task automatic test_fairness();
        bit ok;
        do_reset();
        req_data = 32'h4433_2211;
        req = 4'b1111;
        for (int g = 0; g < 12; g++) begin
            wait_send(ok);
            checks++; if (!ok) begin
                errors++; $display("FAIL fair_wait: grant %0d never started", g);
            end
            checks++; if (grant_id !== 2'(g % 4) || tx_data !== 8'(8'h11 * (g % 4 + 1))) begin
                errors++; $display("FAIL fair_order: grant %0d id=%0d data=%0h want %0d %0h", g, grant_id, tx_data, g % 4, 8'h11 * (g % 4 + 1));
            end
            tick(9);
            pulse_done();
            checks++; if (ack !== 4'(1 << (g % 4))) begin
                errors++; $display("FAIL fair_ack: grant %0d ack=%b want %b", g, ack, 4'(1 << (g % 4)));
            end
        end
        req = 4'b0000;
        tick(4);
    endtask

    task automatic test_timeout();
        bit ok;
        int n_hi;
        req_data[15:8] = 8'hC3;
        req = 4'b0010;
        wait_send(ok);
        checks++; if (!ok || grant_id !== 2'd1) begin
            errors++; $display("FAIL tmo_grant: ok=%b id=%0d want 1 1", ok, grant_id);
        end
        n_hi = 0;
        while (tx_send_en && n_hi < 100) begin
            n_hi++;
            tick(1);
        end
        checks++; if (n_hi !== TMO) begin
            errors++; $display("FAIL tmo_length: high_cycles=%0d want %0d", n_hi, TMO);
        end
        checks++; if (ack !== 4'b0010 || ack_err !== 1'b1) begin
            errors++; $display("FAIL tmo_ack: ack=%b err=%b want 0010 1", ack, ack_err);
        end
        req = 4'b0000;
        req_data[31:24] = 8'h5A;
        req[3] = 1'b1;
        tick(1);
        wait_send(ok);
        checks++; if (!ok || grant_id !== 2'd3 || tx_data !== 8'h5A) begin
            errors++; $display("FAIL tmo_next: ok=%b id=%0d data=%0h want 1 3 5a", ok, grant_id, tx_data);
        end
        tick(2);
        pulse_done();
        checks++; if (ack !== 4'b1000 || ack_err !== 1'b0) begin
            errors++; $display("FAIL tmo_next_ack: ack=%b err=%b want 1000 0", ack, ack_err);
        end
        req = 4'b0000;
        tick(3);
    endtask

    task automatic test_reset_mid_send();
        bit ok;
        req_data[7:0] = 8'h87;
        req = 4'b0001;
        wait_send(ok);
        checks++; if (!ok) begin
            errors++; $display("FAIL rst_mid_start: send never started");
        end
        tick(20);
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({ack, ack_err, busy, grant_id, tx_data, tx_send_en, tx_baud_set} !== 21'd0) begin
            errors++; $display("FAIL rst_mid_async: got %0h want 0", {ack, ack_err, busy, grant_id, tx_data, tx_send_en, tx_baud_set});
        end
        req = 4'b1001;
        tick(2);
        checks++; if (ack !== 4'd0 || tx_send_en !== 1'b0) begin
            errors++; $display("FAIL rst_mid_noack: ack=%b send_en=%b want 0000 0", ack, tx_send_en);
        end
        reset_n = 1'b1;
        tick(1);
        checks++; if (grant_id !== 2'd0 || tx_send_en !== 1'b1 || tx_data !== 8'h87) begin
            errors++; $display("FAIL rst_mid_first: id=%0d send_en=%b data=%0h want 0 1 87", grant_id, tx_send_en, tx_data);
        end
        tick(2);
        pulse_done();
        checks++; if (ack !== 4'b0001) begin
            errors++; $display("FAIL rst_mid_ack0: ack=%b want 0001", ack);
        end
        req = 4'b1000;
        wait_send(ok);
        checks++; if (!ok || grant_id !== 2'd3) begin
            errors++; $display("FAIL rst_mid_second: ok=%b id=%0d want 1 3", ok, grant_id);
        end
        tick(2);
        pulse_done();
        checks++; if (ack !== 4'b1000) begin
            errors++; $display("FAIL rst_mid_ack3: ack=%b want 1000", ack);
        end
        req = 4'b0000;
        tick(3);
    endtask

    task automatic test_spurious_done();
        bit ok;
        pulse_done();
        checks++; if (ack !== 4'd0 || busy !== 1'b0 || tx_send_en !== 1'b0 || grant_id !== 2'd3) begin
            errors++; $display("FAIL spur_idle: ack=%b busy=%b send_en=%b id=%0d want 0000 0 0 3", ack, busy, tx_send_en, grant_id);
        end
        req = 4'b0100;
        wait_send(ok);
        checks++; if (!ok || grant_id !== 2'd2) begin
            errors++; $display("FAIL spur_grant: ok=%b id=%0d want 1 2", ok, grant_id);
        end
        tick(2);
        pulse_done();
        checks++; if (ack !== 4'b0100) begin
            errors++; $display("FAIL spur_ack: ack=%b want 0100", ack);
        end
        req = 4'b0000;
        pulse_done();
        checks++; if (ack !== 4'd0 || busy !== 1'b1 || tx_send_en !== 1'b0) begin
            errors++; $display("FAIL spur_gap: ack=%b busy=%b send_en=%b want 0000 1 0", ack, busy, tx_send_en);
        end
        tick(1);
        checks++; if (ack !== 4'd0 || busy !== 1'b0) begin
            errors++; $display("FAIL spur_gap_end: ack=%b busy=%b want 0000 0", ack, busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_timeout();
        test_reset_mid_send();
        test_spurious_done();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
